// File: rtl/matmul_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : matmul_ctrl
//  Description : Sequencer for an external 4x4 systolic array of 8-bit
//                unsigned elements. Latches the A/B operands, clears the
//                array, waits LAT run cycles, captures the product and holds
//                it until the consumer acknowledges.
//  Revision    : 1.0 - initial release
// ============================================================================
module matmul_ctrl #(
    parameter int LAT = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    input  logic [127:0] a_mat_i,
    input  logic [127:0] b_mat_i,
    input  logic         abort_i,
    input  logic         res_ack_i,
    input  logic [127:0] arr_res_i,
    output logic         arr_rst_o,
    output logic [127:0] arr_a_o,
    output logic [127:0] arr_b_o,
    output logic         ready_o,
    output logic         busy_o,
    output logic [127:0] res_o,
    output logic         res_valid_o,
    output logic [15:0]  ops_cnt_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_RUN   = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    // Run-counter value on which the array result is captured.
    localparam logic [7:0]  c_LAT_CNT = 8'(LAT);
    localparam logic [15:0] c_OPS_MAX = 16'hFFFF;

    state_t       state_q, state_d;
    logic [7:0]   cnt_q, cnt_d;
    logic [127:0] arr_a_q, arr_a_d;
    logic [127:0] arr_b_q, arr_b_d;
    logic [127:0] res_q, res_d;
    logic         res_valid_q, res_valid_d;
    logic [15:0]  ops_cnt_q, ops_cnt_d;

    // State and datapath registers; reset wins over every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 8'd0;
            arr_a_q     <= '0;
            arr_b_q     <= '0;
            res_q       <= '0;
            res_valid_q <= 1'b0;
            ops_cnt_q   <= 16'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            arr_a_q     <= arr_a_d;
            arr_b_q     <= arr_b_d;
            res_q       <= res_d;
            res_valid_q <= res_valid_d;
            ops_cnt_q   <= ops_cnt_d;
        end
    end

    // Next-state and datapath update logic.
    // cnt counts RUN edges starting from zero on RUN entry, so the capture
    // edge lands LAT+2 edges after the edge that accepted start (one edge
    // for CLEAR, one to enter RUN, LAT more while running).
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        arr_a_d     = arr_a_q;
        arr_b_d     = arr_b_q;
        res_d       = res_q;
        res_valid_d = res_valid_q;
        ops_cnt_d   = ops_cnt_q;

        case (state_q)
            S_IDLE: begin
                // abort and res_ack are meaningless here; only start matters
                if (start_i) begin
                    arr_a_d = a_mat_i;
                    arr_b_d = b_mat_i;
                    cnt_d   = 8'd0;
                    state_d = S_CLEAR;
                end
            end

            S_CLEAR: begin
                cnt_d   = 8'd0;
                state_d = abort_i ? S_IDLE : S_RUN;
            end

            S_RUN: begin
                if (abort_i) begin
                    cnt_d   = 8'd0;
                    state_d = S_IDLE;
                end else if (cnt_q == c_LAT_CNT) begin
                    res_d       = arr_res_i;
                    res_valid_d = 1'b1;
                    if (ops_cnt_q != c_OPS_MAX) begin
                        ops_cnt_d = ops_cnt_q + 16'd1;
                    end
                    cnt_d   = 8'd0;
                    state_d = S_HOLD;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            S_HOLD: begin
                // abort doubles as an acknowledge; start is never sampled here
                if (res_ack_i || abort_i) begin
                    res_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Array clear is combinational so an abort reaches the array in the
    // same cycle it is raised.
    assign arr_rst_o   = rst | (state_q == S_CLEAR) | (abort_i & (state_q != S_IDLE));
    assign arr_a_o     = arr_a_q;
    assign arr_b_o     = arr_b_q;
    assign ready_o     = (state_q == S_IDLE);
    assign busy_o      = (state_q == S_CLEAR) | (state_q == S_RUN);
    assign res_o       = res_q;
    assign res_valid_o = res_valid_q;
    assign ops_cnt_o   = ops_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_matmul_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_matmul_ctrl
//  Description : Randomized scoreboard bench for matmul_ctrl with a
//                behavioural 4x4 array model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_matmul_ctrl;

    localparam int LAT = 12;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] a_mat;
    logic [127:0] b_mat;
    logic         abort;
    logic         res_ack;
    logic [127:0] arr_res;
    logic         arr_rst;
    logic [127:0] arr_a;
    logic [127:0] arr_b;
    logic         ready;
    logic         busy;
    logic [127:0] res;
    logic         res_valid;
    logic [15:0]  ops_cnt;

    matmul_ctrl #(.LAT(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start),
        .a_mat_i    (a_mat),
        .b_mat_i    (b_mat),
        .abort_i    (abort),
        .res_ack_i  (res_ack),
        .arr_res_i  (arr_res),
        .arr_rst_o  (arr_rst),
        .arr_a_o    (arr_a),
        .arr_b_o    (arr_b),
        .ready_o    (ready),
        .busy_o     (busy),
        .res_o      (res),
        .res_valid_o(res_valid),
        .ops_cnt_o  (ops_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [127:0] prod;
        int           vcyc;
        int           ops;
    } exp_t;

    exp_t sbq[$];
    int   model_ops = 0;

    // Reference product: C(i,j) = sum_k A(i,k)*B(k,j), mod 256.
    function automatic logic [127:0] mm(input logic [127:0] a, input logic [127:0] b);
        logic [127:0] r;
        int s;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                s = 0;
                for (int k = 0; k < 4; k++) begin
                    s += int'(a[(4*i+k)*8 +: 8]) * int'(b[(4*k+j)*8 +: 8]);
                end
                r[(4*i+j)*8 +: 8] = 8'(s % 256);
            end
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Array model: the product is only presented in the one cycle where
    // exactly LAT edges have passed since clear was released.
    int run_edges = 0;
    always @(posedge clk) begin
        if (arr_rst)               run_edges <= 0;
        else if (run_edges < 1000) run_edges <= run_edges + 1;
    end
    always_comb arr_res = (run_edges == LAT) ? mm(arr_a, arr_b) : ~mm(arr_a, arr_b);

    // Monitor: pops the scoreboard when a result appears, checks it stays put.
    logic         prev_valid = 1'b0;
    logic [127:0] hold_exp   = '0;
    exp_t         mon_e;
    always @(negedge clk) begin
        if (res_valid && !prev_valid) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result: got %h expected none", res);
            end else begin
                mon_e = sbq.pop_front();
                chk("result", res, mon_e.prod);
                chk("latency", 128'(cyc), 128'(mon_e.vcyc));
                chk("ops_cnt", 128'(ops_cnt), 128'(mon_e.ops));
                hold_exp = mon_e.prod;
            end
        end else if (res_valid) begin
            chk("hold_stable", res, hold_exp);
        end
        prev_valid = res_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Drive one accepted start and record the expected outcome.
    task automatic issue(input logic [127:0] a, input logic [127:0] b);
        exp_t e;
        chk("ready_before_start", 128'(ready), 128'(1));
        a_mat = a;
        b_mat = b;
        start = 1'b1;
        model_ops = (model_ops < 65535) ? model_ops + 1 : model_ops;
        e.prod = mm(a, b);
        e.vcyc = cyc + 1 + LAT + 2;
        e.ops  = model_ops;
        sbq.push_back(e);
        tick();
        start = 1'b0;
    endtask

    // Wait (bounded) for the result; optionally spray ignored start/ack.
    task automatic wait_valid(input bit noise);
        int n;
        n = 0;
        while (!res_valid && n < LAT + 10) begin
            chk("busy_running", 128'({busy, ready}), 128'(2'b10));
            if (noise) begin
                start   = 1'b1;
                a_mat   = rnd128();
                b_mat   = rnd128();
                res_ack = 1'($urandom);
            end
            tick();
            n++;
        end
        start   = 1'b0;
        res_ack = 1'b0;
        total++;
        if (!res_valid) begin
            bad++;
            $display("FAIL wait_valid: got res_valid=0 expected 1 within %0d cycles", LAT + 10);
        end
    endtask

    // Release the held result via res_ack or abort, optionally with start.
    task automatic ack_op(input bit use_abort, input bit with_start);
        int d;
        d = $urandom_range(0, 3);
        for (int i = 0; i < d; i++) begin
            tick();
            chk("hold_ready_low", 128'({ready, res_valid}), 128'(2'b01));
        end
        if (use_abort) abort = 1'b1;
        else           res_ack = 1'b1;
        if (with_start) begin
            start = 1'b1;
            a_mat = rnd128();
            b_mat = rnd128();
        end
        tick();
        abort   = 1'b0;
        res_ack = 1'b0;
        start   = 1'b0;
        chk("after_ack", 128'({ready, busy, res_valid}), 128'(3'b100));
    endtask

    function automatic logic [127:0] ident();
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) r[(4*i+i)*8 +: 8] = 8'd1;
        return r;
    endfunction

    function automatic logic [127:0] seq16();
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[i*8 +: 8] = 8'(i);
        return r;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst = 1'b1; start = 1'b0; abort = 1'b0; res_ack = 1'b0;
        a_mat = '0; b_mat = '0;
        tick();
        chk("arr_rst_in_reset", 128'(arr_rst), 128'(1));
        start = 1'b1; abort = 1'b1; a_mat = rnd128();
        tick();
        chk("reset_overrides", 128'({ready, busy, arr_rst}), 128'(3'b101));
        start = 1'b0; abort = 1'b0;
        rst = 1'b0;
        #1;
        chk("reset_flags", 128'({ready, busy, res_valid, arr_rst}), 128'(4'b1000));
        chk("reset_res", res, '0);
        chk("reset_arr_a", arr_a, '0);
        chk("reset_ops", 128'(ops_cnt), 128'(0));

        // abort while idle does nothing
        abort = 1'b1;
        #1;
        chk("idle_abort_arr_rst", 128'(arr_rst), 128'(0));
        tick();
        abort = 1'b0;
        chk("idle_abort_ready", 128'(ready), 128'(1));

        // directed products
        issue(ident(), seq16());  wait_valid(1'b0); ack_op(1'b0, 1'b0);
        issue({16{8'h01}}, {16{8'h01}}); wait_valid(1'b0); ack_op(1'b0, 1'b0);
        issue({16{8'h10}}, {16{8'h10}}); wait_valid(1'b0); ack_op(1'b0, 1'b0);

        // start/ack noise while busy is ignored
        issue(rnd128(), rnd128()); wait_valid(1'b1); ack_op(1'b0, 1'b0);

        // abort mid-run at cnt=5, then at a random point
        for (int r = 0; r < 2; r++) begin
            issue(rnd128(), rnd128());
            k = (r == 0) ? 6 : $urandom_range(0, LAT);
            for (int i = 0; i < k; i++) tick();
            abort = 1'b1;
            #1;
            chk("abort_arr_rst", 128'(arr_rst), 128'(1));
            tick();
            abort = 1'b0;
            void'(sbq.pop_back());
            model_ops--;
            chk("abort_idle", 128'({ready, busy, res_valid}), 128'(3'b100));
            chk("abort_ops", 128'(ops_cnt), 128'(model_ops));
            issue(rnd128(), rnd128()); wait_valid(1'b0); ack_op(1'b0, 1'b0);
        end

        // ack with start in the same HOLD cycle, then start right after
        issue(rnd128(), rnd128()); wait_valid(1'b0); ack_op(1'b0, 1'b1);
        issue(rnd128(), rnd128()); wait_valid(1'b0);
        // abort in HOLD acts as ack
        ack_op(1'b1, 1'b0);

        // random mix
        for (int r = 0; r < 8; r++) begin
            issue(rnd128(), rnd128());
            wait_valid(1'($urandom));
            ack_op(1'($urandom), 1'($urandom));
        end

        // reset in HOLD
        issue(rnd128(), rnd128()); wait_valid(1'b0);
        rst = 1'b1;
        #1;
        chk("hold_rst_arr_rst", 128'(arr_rst), 128'(1));
        tick();
        rst = 1'b0;
        model_ops = 0;
        sbq.delete();
        chk("hold_rst_res", res, '0);
        chk("hold_rst_flags", 128'({ready, busy, res_valid}), 128'(3'b100));
        chk("hold_rst_ops", 128'(ops_cnt), 128'(0));
        issue(rnd128(), rnd128()); wait_valid(1'b0); ack_op(1'b0, 1'b0);

        tick();
        tick();
        chk("scoreboard_empty", 128'(sbq.size()), 128'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
